// File: rtl/cpu_ec2_core.sv
// EC-2 accumulator core: controller FSM, datapath and unified program/data memory.
// Instructions are {op[2:0], pad, addr}; I/O uses valid/ready handshakes.
module cpu_ec2_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        ir_op,
    output logic              a_neq0,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT_IN,
        S_WAIT_OUT,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_IN    = 3'b100,
        OP_OUT   = 3'b101,
        OP_JNZ   = 3'b110,
        OP_HALT  = 3'b111
    } op_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] a_reg, a_next;
    logic [DATA_W-1:0] ir_reg, ir_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [DATA_W-1:0] out_reg, out_next;
    logic              out_valid_reg, out_valid_next;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    op_t               ir_opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic [DATA_W-1:0] operand;

    assign ir_opcode = op_t'(ir_reg[DATA_W-1 -: 3]);
    assign ir_addr   = ir_reg[ADDR_W-1:0];
    assign operand   = mem[ir_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            a_reg         <= '0;
            ir_reg        <= '0;
            pc_reg        <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            a_reg         <= a_next;
            ir_reg        <= ir_next;
            pc_reg        <= pc_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
        end
    end

    // Memory is not reset; a write is suppressed on any edge seen while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_next     = state_reg;
        a_next         = a_reg;
        ir_next        = ir_reg;
        pc_next        = pc_reg;
        out_next       = out_reg;
        out_valid_next = out_valid_reg;
        mem_we         = 1'b0;
        mem_waddr      = ir_addr;
        mem_wdata      = a_reg;

        case (state_reg)
            S_IDLE, S_HALT: begin
                if (prog_we) begin
                    mem_we    = 1'b1;
                    mem_waddr = prog_addr;
                    mem_wdata = prog_data;
                end
                if (start) begin
                    state_next = S_FETCH;
                    pc_next    = '0;
                    a_next     = '0;
                end
            end
            S_FETCH: begin
                ir_next    = mem[pc_reg];
                pc_next    = pc_reg + 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                state_next = S_FETCH;
                case (ir_opcode)
                    OP_LOAD:  a_next = operand;
                    OP_STORE: mem_we = 1'b1;
                    OP_ADD:   a_next = a_reg + operand;
                    OP_SUB:   a_next = a_reg - operand;
                    OP_IN:    state_next = S_WAIT_IN;
                    OP_OUT: begin
                        out_next       = a_reg;
                        out_valid_next = 1'b1;
                        state_next     = S_WAIT_OUT;
                    end
                    OP_JNZ: begin
                        if (a_reg != '0) begin
                            pc_next = ir_addr;
                        end
                    end
                    OP_HALT:  state_next = S_HALT;
                    default:  state_next = S_FETCH;
                endcase
            end
            S_WAIT_IN: begin
                if (in_valid) begin
                    a_next     = in_data;
                    state_next = S_FETCH;
                end
            end
            S_WAIT_OUT: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = S_FETCH;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign in_ready  = (state_reg == S_WAIT_IN);
    assign halted    = (state_reg == S_HALT);
    assign out_data  = out_reg;
    assign out_valid = out_valid_reg;
    assign ir_op     = ir_reg[DATA_W-1 -: 3];
    assign a_neq0    = |a_reg;
    assign pc        = pc_reg;

endmodule

// File: tb/tb_cpu_ec2_core.sv
// Bench for cpu_ec2_core: table of small programs plus hand-written handshake,
// back-pressure, reset and load-lockout sequences; outputs checked via a queue.
module tb_cpu_ec2_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       prog_we;
    logic [4:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] ir_op;
    logic       a_neq0;
    logic [4:0] pc;
    logic       halted;

    cpu_ec2_core #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ir_op     (ir_op),
        .a_neq0    (a_neq0),
        .pc        (pc),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0][7:0] code;
        logic [7:0]      m29;
        logic [7:0]      m30;
        logic [7:0]      m31;
        int              nout;
        logic [3:0][7:0] outs;
        logic [4:0]      exp_pc;
        logic            exp_nz;
    } vec_t;

    localparam int NVEC = 5;
    vec_t vecs [NVEC];

    logic [7:0] exp_q [$];
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", nm, act);
        end
    endtask

    // Handshake is sampled mid-cycle; it completes on the following rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected output: got 0x%0h, expected none", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("output word", {24'd0, out_data}, {24'd0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [4:0] addr, input logic [7:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic load_vec(input int k);
        logic [7:0] w;
        logic [4:0] a5;
        for (int a = 0; a < 32; a++) begin
            w  = 8'hE0;
            a5 = a[4:0];
            if (a < 8)        w = vecs[k].code[a];
            else if (a == 29) w = vecs[k].m29;
            else if (a == 30) w = vecs[k].m30;
            else if (a == 31) w = vecs[k].m31;
            load_word(a5, w);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halt(input string nm);
        int n;
        n = 0;
        while (!halted && n < 500) begin
            tick();
            n++;
        end
        check({nm, " reaches halt"}, {31'd0, halted}, 32'd1);
    endtask

    task automatic wait_in_ready(input string nm);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({nm, " in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic wait_out_valid(input string nm);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check({nm, " out_valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        // Program table: code at M0..M7, data at M29..M31, unused words are HALT.
        for (int k = 0; k < NVEC; k++) begin
            vecs[k].code   = {8{8'hE0}};
            vecs[k].m29    = 8'h00;
            vecs[k].m30    = 8'h00;
            vecs[k].m31    = 8'hE0;
            vecs[k].nout   = 0;
            vecs[k].outs   = '0;
            vecs[k].exp_pc = 5'd0;
            vecs[k].exp_nz = 1'b0;
        end
        // countdown 3 -> outputs 2,1,0
        vecs[0].code[0] = 8'h1E; vecs[0].code[1] = 8'h7F; vecs[0].code[2] = 8'hA0;
        vecs[0].code[3] = 8'hC1; vecs[0].code[4] = 8'hE0;
        vecs[0].m30 = 8'd3; vecs[0].m31 = 8'd1;
        vecs[0].nout = 3; vecs[0].outs[0] = 8'd2; vecs[0].outs[1] = 8'd1; vecs[0].outs[2] = 8'd0;
        vecs[0].exp_pc = 5'd5; vecs[0].exp_nz = 1'b0;
        // 0xFF + 0x02 wraps to 0x01, through STORE/LOAD of M29
        vecs[1].code[0] = 8'h1E; vecs[1].code[1] = 8'h5F; vecs[1].code[2] = 8'h3D;
        vecs[1].code[3] = 8'h1D; vecs[1].code[4] = 8'hA0; vecs[1].code[5] = 8'hE0;
        vecs[1].m30 = 8'hFF; vecs[1].m31 = 8'h02;
        vecs[1].nout = 1; vecs[1].outs[0] = 8'h01;
        vecs[1].exp_pc = 5'd6; vecs[1].exp_nz = 1'b1;
        // 0x02 - 0x05 underflows to 0xFD
        vecs[2].code[0] = 8'h1F; vecs[2].code[1] = 8'h7E; vecs[2].code[2] = 8'hA0;
        vecs[2].code[3] = 8'hE0;
        vecs[2].m30 = 8'h05; vecs[2].m31 = 8'h02;
        vecs[2].nout = 1; vecs[2].outs[0] = 8'hFD;
        vecs[2].exp_pc = 5'd4; vecs[2].exp_nz = 1'b1;
        // STORE overwrites the next instruction with OUT
        vecs[3].code[0] = 8'h1E; vecs[3].code[1] = 8'h22; vecs[3].code[2] = 8'hE0;
        vecs[3].code[3] = 8'hE0;
        vecs[3].m30 = 8'hA0;
        vecs[3].nout = 1; vecs[3].outs[0] = 8'hA0;
        vecs[3].exp_pc = 5'd4; vecs[3].exp_nz = 1'b1;
        // JNZ to 31; fetching the HALT there wraps PC to 0
        vecs[4].code[0] = 8'h1E; vecs[4].code[1] = 8'hA0; vecs[4].code[2] = 8'hDF;
        vecs[4].code[3] = 8'hE0;
        vecs[4].m30 = 8'h55; vecs[4].m31 = 8'hE0;
        vecs[4].nout = 1; vecs[4].outs[0] = 8'h55;
        vecs[4].exp_pc = 5'd0; vecs[4].exp_nz = 1'b1;

        rst_n = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();

        check("reset pc",        {27'd0, pc},        32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_data",  {24'd0, out_data},  32'd0);
        check("reset halted",    {31'd0, halted},    32'd0);
        check("reset a_neq0",    {31'd0, a_neq0},    32'd0);
        check("reset ir_op",     {29'd0, ir_op},     32'd0);
        check("reset in_ready",  {31'd0, in_ready},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < NVEC; k++) begin
            load_vec(k);
            for (int j = 0; j < vecs[k].nout; j++) exp_q.push_back(vecs[k].outs[j]);
            pulse_start();
            wait_halt($sformatf("vec%0d", k));
            check($sformatf("vec%0d pc", k),     {27'd0, pc},     {27'd0, vecs[k].exp_pc});
            check($sformatf("vec%0d a_neq0", k), {31'd0, a_neq0}, {31'd0, vecs[k].exp_nz});
            check($sformatf("vec%0d ir_op", k),  {29'd0, ir_op},  32'd7);
            check($sformatf("vec%0d drained", k), exp_q.size(), 32'd0);
        end

        // Input handshake with a late InValid
        load_word(5'd0, 8'h80); load_word(5'd1, 8'hA0); load_word(5'd2, 8'hE0);
        out_ready = 1'b1;
        exp_q.push_back(8'h5A);
        pulse_start();
        wait_in_ready("in-hs");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("in-hs hold%0d in_ready", i), {31'd0, in_ready}, 32'd1);
            tick();
        end
        in_valid = 1'b1; in_data = 8'h5A;
        check("in-hs accept in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("in-hs a_neq0", {31'd0, a_neq0}, 32'd1);
        wait_halt("in-hs");
        check("in-hs pc", {27'd0, pc}, 32'd3);
        check("in-hs in_ready low", {31'd0, in_ready}, 32'd0);

        // Output back-pressure
        load_word(5'd0, 8'h1E); load_word(5'd1, 8'hA0); load_word(5'd2, 8'hE0);
        load_word(5'd30, 8'h33);
        out_ready = 1'b0;
        exp_q.push_back(8'h33);
        pulse_start();
        wait_out_valid("bp");
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp stall%0d out_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp stall%0d out_data", i),  {24'd0, out_data},  32'h33);
            check($sformatf("bp stall%0d pc", i),        {27'd0, pc},        32'd2);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp released out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("bp fetch resumed pc", {27'd0, pc}, 32'd3);
        wait_halt("bp");
        check("bp drained", exp_q.size(), 32'd0);

        // Reset in WAIT_OUT, then rerun from retained memory
        out_ready = 1'b0;
        pulse_start();
        wait_out_valid("rst");
        rst_n = 1'b0;
        #2;
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst pc",        {27'd0, pc},        32'd0);
        check("rst a_neq0",    {31'd0, a_neq0},    32'd0);
        check("rst out_data",  {24'd0, out_data},  32'd0);
        check("rst halted",    {31'd0, halted},    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        exp_q.push_back(8'h33);
        pulse_start();
        wait_halt("rst rerun");
        check("rst rerun pc", {27'd0, pc}, 32'd3);
        check("rst rerun drained", exp_q.size(), 32'd0);

        // Program-load lockout while running
        load_word(5'd0, 8'h80);
        pulse_start();
        wait_in_ready("lock");
        prog_we = 1'b1; prog_addr = 5'd0; prog_data = 8'hE0; start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        check("lock start ignored pc", {27'd0, pc}, 32'd1);
        check("lock still waiting",    {31'd0, in_ready}, 32'd1);
        exp_q.push_back(8'h11);
        in_valid = 1'b1; in_data = 8'h11;
        tick();
        in_valid = 1'b0;
        wait_halt("lock");
        exp_q.push_back(8'h22);
        pulse_start();
        wait_in_ready("lock M0 kept");
        in_valid = 1'b1; in_data = 8'h22;
        tick();
        in_valid = 1'b0;
        wait_halt("lock rerun");
        check("lock drained", exp_q.size(), 32'd0);

        // ProgWe and Start together: new M0 (HALT) runs first
        prog_we = 1'b1; prog_addr = 5'd0; prog_data = 8'hE0; start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        wait_halt("we+start");
        check("we+start pc",     {27'd0, pc},     32'd1);
        check("we+start a_neq0", {31'd0, a_neq0}, 32'd0);
        repeat (3) tick();
        check("final drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
